cp0_exc_ctrl: RTL
=================

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 4, number of external interrupt lines (1..8).
REQ-002 Parameter EXC_VEC, default 32'h0000_0008, handler entry address.
REQ-003 Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Clrn  in  1  reset; asynchronous, active-low.
REQ-005 irq  in  NUM_IRQ  level external interrupt requests, asynchronous to Clk.
REQ-006 pc  in  32  address of the instruction executing this cycle.
REQ-007 ov / sys / unimpl  in  1 each  ALU overflow on a trapping op, syscall decoded, unimplemented opcode.
REQ-008 mtc0 / mfc0 / eret  in  1 each  decoded CP0 instructions, mutually exclusive.
REQ-009 c0_rd  in  5  CP0 register number; c0_wdata  in  32  mtc0 write data (rt).
REQ-010 c0_rdata  out  32  mfc0 read data.
REQ-011 redirect  out  1  PC source override this cycle; target  out  32  override address.
REQ-012 kill  out  1  suppress register-file and data-memory write of current instruction.
REQ-013 status, cause, epc  out  32 each  architectural CP0 register values.

Function
REQ-014 Register map: 12=Status, 13=Cause, 14=EPC; any other c0_rd reads 0 and ignores writes.
REQ-015 Status bits: [0]=IE, [1]=EXL, [8+NUM_IRQ-1:8]=IM; other bits read 0.
REQ-016 Cause bits: [6:2]=ExcCode, [8+NUM_IRQ-1:8]=IP; other bits read 0; Cause is read-only to mtc0.
REQ-017 ExcCode values: Int=0, Sys=8, RI=10, Ov=12.
REQ-018 Each irq bit passes a 2-flop synchronizer; IP is loaded every cycle from the synchronized value (level-sensitive, 3-edge latency irq->IP).
REQ-019 Interrupt pending = IE & ~EXL & |(IP & IM).
REQ-020 Priority, highest first: unimpl, sys, ov, interrupt; only the highest event is taken.
REQ-021 Taking an event (combinational, same cycle): redirect=1, target=EXC_VEC, kill=1.
REQ-022 At the next edge after an event: ExcCode loaded; EPC<=pc if EXL=0, unchanged if EXL=1; EXL<=1.
REQ-023 Interrupts are not taken in a cycle with eret or mtc0 asserted; they are taken on the next eligible instruction.
REQ-024 eret: redirect=1, target=epc, kill=0; EXL<=0 at the edge; valid even with EXL=0.
REQ-025 mtc0 to Status/EPC updates the register at the edge; if an event is taken in the same cycle, the write is dropped.
REQ-026 mfc0 returns the pre-edge register value combinationally; mfc0 of Cause reflects the current IP.
REQ-027 FSM: RUN (EXL=0) -> HANDLER on any taken event; HANDLER -> RUN on eret or mtc0 clearing EXL; HANDLER -> HANDLER on nested synchronous event.
REQ-028 No event and no eret: redirect=0, kill=0, target=0.

Reset
REQ-029 Clrn low asynchronously clears Status, Cause, EPC and synchronizers to 0, and forces state RUN.
REQ-030 While Clrn is low, redirect=0, kill=0, c0_rdata=0; first event is eligible on the first edge after release.

Structure
REQ-031 Shared package cp0_pkg holds ExcCode constants, CP0 register numbers, and Status/Cause bit positions.
REQ-032 One sub-module irq_sync (parameterized-width 2-flop synchronizer); everything else is in cp0_exc_ctrl.

Verification
REQ-033 After reset: mtc0 Status=32'h0000_0F01, irq=4'b0100 for 3 cycles, pc=32'h40 -> redirect=1, target=8, kill=1; next edge: EPC=32'h40, Cause=32'h0000_0400, Status=32'h0000_0F03.
REQ-034 Same cycle ov=1 and sys=1 at pc=32'h20 -> ExcCode=8 (Cause[6:2]), EPC=32'h20.
REQ-035 In HANDLER, unimpl at pc=32'h10 -> ExcCode=10, EPC keeps 32'h40, EXL stays 1.
REQ-036 eret with EPC=32'h40 -> redirect=1, target=32'h40, kill=0; next edge EXL=0; pending irq with IE=1 is taken at the next instruction.
REQ-037 mtc0 EPC=32'h100 in the same cycle as sys=1 at pc=32'h24 -> EPC=32'h24 (write dropped).
REQ-038 Clrn pulsed low mid-handler (EXL=1) -> all registers 0 immediately, redirect=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and bit positions
package cp0_pkg;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    localparam int ST_IE         = 0;
    localparam int ST_EXL        = 1;
    localparam int ST_IM_LSB     = 8;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - parameterized-width two-flop synchronizer
module irq_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 Status/Cause/EPC with exception and interrupt control
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ = 4,
    parameter logic [31:0] EXC_VEC = 32'h0000_0008
) (
    input  logic               Clk,
    input  logic               Clrn,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [31:0]        pc,
    input  logic               ov,
    input  logic               sys,
    input  logic               unimpl,
    input  logic               mtc0,
    input  logic               mfc0,
    input  logic               eret,
    input  logic [4:0]         c0_rd,
    input  logic [31:0]        c0_wdata,
    output logic [31:0]        c0_rdata,
    output logic               redirect,
    output logic [31:0]        target,
    output logic               kill,
    output logic [31:0]        status,
    output logic [31:0]        cause,
    output logic [31:0]        epc
);

    cp0_state_e         state_q, state_d;
    logic               ie_q;
    logic [NUM_IRQ-1:0] im_q;
    logic [NUM_IRQ-1:0] ip_q;
    logic [NUM_IRQ-1:0] irq_s;
    logic [4:0]         exc_q;
    logic [31:0]        epc_q;

    logic               exl;
    logic               int_pend;
    logic               take_int;
    logic               exc_taken;
    logic [4:0]         exc_code;
    logic               wr_status;
    logic               wr_epc;

    irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
        .clk   (Clk),
        .rst_n (Clrn),
        .d     (irq),
        .q     (irq_s)
    );

    // EXL is held by the FSM state rather than a separate flop
    assign exl       = (state_q == HANDLER);
    assign int_pend  = ie_q & ~exl & (|(ip_q & im_q));
    assign take_int  = int_pend & ~eret & ~mtc0;
    assign exc_taken = unimpl | sys | ov | take_int;
    assign wr_status = mtc0 & (c0_rd == REG_STATUS) & ~exc_taken;
    assign wr_epc    = mtc0 & (c0_rd == REG_EPC) & ~exc_taken;

    always_comb begin
        exc_code = EXC_INT;
        if (unimpl)   exc_code = EXC_RI;
        else if (sys) exc_code = EXC_SYS;
        else if (ov)  exc_code = EXC_OV;
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (exc_taken)                          state_d = HANDLER;
                else if (wr_status && c0_wdata[ST_EXL]) state_d = HANDLER;
            end
            HANDLER: begin
                if (exc_taken)                           state_d = HANDLER;
                else if (eret)                           state_d = RUN;
                else if (wr_status && !c0_wdata[ST_EXL]) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        redirect = 1'b0;
        kill     = 1'b0;
        target   = '0;
        if (Clrn) begin
            if (exc_taken) begin
                redirect = 1'b1;
                kill     = 1'b1;
                target   = EXC_VEC;
            end else if (eret) begin
                redirect = 1'b1;
                target   = epc_q;
            end
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            ie_q  <= 1'b0;
            im_q  <= '0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            ip_q <= irq_s;
            if (wr_status) begin
                ie_q <= c0_wdata[ST_IE];
                im_q <= c0_wdata[ST_IM_LSB +: NUM_IRQ];
            end
            if (exc_taken) exc_q <= exc_code;
            // nested events keep the EPC of the outermost one
            if (exc_taken && !exl) epc_q <= pc;
            else if (wr_epc)       epc_q <= c0_wdata;
        end
    end

    always_comb begin
        status                             = '0;
        status[ST_IE]                      = ie_q;
        status[ST_EXL]                     = exl;
        status[ST_IM_LSB +: NUM_IRQ]       = im_q;
        cause                              = '0;
        cause[CAUSE_EXC_LSB +: 5]          = exc_q;
        cause[CAUSE_IP_LSB +: NUM_IRQ]     = ip_q;
        epc                                = epc_q;
    end

    always_comb begin
        c0_rdata = '0;
        if (Clrn && mfc0) begin
            case (c0_rd)
                REG_STATUS: c0_rdata = status;
                REG_CAUSE:  c0_rdata = cause;
                REG_EPC:    c0_rdata = epc;
                default:    c0_rdata = '0;
            endcase
        end
    end

endmodule
